pctoz_loader: RTL and testbench

//   PC-to-RAM loader. Takes bytes received from the PC UART, packs every 4 bytes MSB-first into one
//   32-bit word and writes NUM_WORDS words to consecutive RAM addresses from BASE_ADDR.

---
 rtl/pctoz_loader.sv | 200 ++++++++++++++++++++
 tb/tb_pctoz_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pctoz_loader.sv
// PC-to-RAM loader: packs UART bytes MSB-first into 32-bit words and writes
// NUM_WORDS of them to consecutive RAM addresses starting at BASE_ADDR.
module pctoz_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h10003A00,
  parameter int unsigned NUM_WORDS = 8,
  parameter int unsigned TIMEOUT   = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxvalid,
  input  logic [7:0]  rxdata,
  input  logic        gnt_i,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] w_addr,
  output logic [31:0] w_data,
  output logic        busy,
  output logic        done_o,
  output logic        err_ovr,
  output logic        err_tmo
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned IDX_W = 8;
  localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         bytecnt_q, bytecnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [23:0]        word_q, word_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_vld_q, hold_vld_d;
  logic               req_q, req_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovr_q, ovr_d;
  logic               tmo_q, tmo_d;

  logic               last_word_c;

  assign last_word_c = (idx_q == IDX_W'(NUM_WORDS - 1));

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    bytecnt_d  = bytecnt_q;
    idx_d      = idx_q;
    tmr_d      = tmr_q;
    word_d     = word_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    req_d      = req_q;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovr_d      = 1'b0;
    tmo_d      = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
        if (rxvalid) begin
          word_d    = {16'h0, rxdata};
          bytecnt_d = 2'd1;
          tmr_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (hold_vld_q) begin
          // Byte captured during the previous write opens the new word; a
          // byte arriving on the same cycle follows it as byte 1.
          hold_vld_d = 1'b0;
          tmr_d      = '0;
          if (rxvalid) begin
            word_d    = {8'h0, hold_q, rxdata};
            bytecnt_d = 2'd2;
          end else begin
            word_d    = {16'h0, hold_q};
            bytecnt_d = 2'd1;
          end
        end else if (rxvalid) begin
          tmr_d = '0;
          if (bytecnt_q == 2'd3) begin
            data_d    = {word_q, rxdata};
            addr_d    = AW'(BASE_ADDR + (AW'(idx_q) << 2));
            req_d     = 1'b1;
            bytecnt_d = 2'd0;
            word_d    = '0;
            state_d   = S_WRITE;
          end else begin
            word_d    = {word_q[15:0], rxdata};
            bytecnt_d = bytecnt_q + 2'd1;
          end
        end else if (bytecnt_q != 2'd0) begin
          if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
            tmo_d     = 1'b1;
            bytecnt_d = 2'd0;
            word_d    = '0;
            tmr_d     = '0;
            if (idx_q == '0) begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
      end

      S_WRITE: begin
        if (rxvalid) begin
          if (hold_vld_q) begin
            ovr_d = 1'b1;
          end else begin
            hold_d     = rxdata;
            hold_vld_d = 1'b1;
          end
        end
        if (gnt_i) begin
          req_d = 1'b0;
          if (last_word_c) begin
            idx_d      = '0;
            hold_vld_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_COLLECT;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bytecnt_q  <= '0;
      idx_q      <= '0;
      tmr_q      <= '0;
      word_q     <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bytecnt_q  <= bytecnt_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      word_q     <= word_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      tmo_q      <= tmo_d;
    end
  end

  assign req_o   = req_q;
  assign we_o    = req_q;
  assign w_addr  = addr_q;
  assign w_data  = data_q;
  assign busy    = busy_q;
  assign done_o  = done_q;
  assign err_ovr = ovr_q;
  assign err_tmo = tmo_q;

endmodule

// File: tb/tb_pctoz_loader.sv
// Directed bench for pctoz_loader: default frame instance plus a
// single-word, short-timeout instance for done and timeout boundaries.
module tb_pctoz_loader;

  localparam logic [31:0] BASE = 32'h10003A00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rxvalid, gnt_i;
  logic [7:0]  rxdata;
  logic        req_o, we_o, busy, done_o, err_ovr, err_tmo;
  logic [31:0] w_addr, w_data;

  logic        rxvalid1, gnt1;
  logic [7:0]  rxdata1;
  logic        req1, we1, busy1, done1, ovr1, tmo1;
  logic [31:0] waddr1, wdata1;

  pctoz_loader dut (
    .clk(clk), .rst(rst), .rxvalid(rxvalid), .rxdata(rxdata), .gnt_i(gnt_i),
    .req_o(req_o), .we_o(we_o), .w_addr(w_addr), .w_data(w_data), .busy(busy),
    .done_o(done_o), .err_ovr(err_ovr), .err_tmo(err_tmo)
  );

  pctoz_loader #(.NUM_WORDS(1), .TIMEOUT(10)) dut1 (
    .clk(clk), .rst(rst), .rxvalid(rxvalid1), .rxdata(rxdata1), .gnt_i(gnt1),
    .req_o(req1), .we_o(we1), .w_addr(waddr1), .w_data(wdata1), .busy(busy1),
    .done_o(done1), .err_ovr(ovr1), .err_tmo(tmo1)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Write log and pulse counters, sampled mid-cycle
  logic [31:0] wa[$], wd[$], wa1[$], wd1[$];
  int done_n = 0, ovr_n = 0, tmo_n = 0, tmo1_n = 0;
  always @(negedge clk) begin
    if (req_o && gnt_i) begin wa.push_back(w_addr); wd.push_back(w_data); end
    if (req1 && gnt1) begin wa1.push_back(waddr1); wd1.push_back(wdata1); end
    if (done_o) done_n++;
    if (err_ovr) ovr_n++;
    if (err_tmo) tmo_n++;
    if (tmo1) tmo1_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rxvalid = 1'b1; rxdata = b;
    step();
    rxvalid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b);
    rxvalid1 = 1'b1; rxdata1 = b;
    step();
    rxvalid1 = 1'b0;
  endtask

  int n0;
  logic [7:0] bb;
  logic [31:0] exp_w;

  initial begin
    rst = 1'b0; rxvalid = 1'b0; rxdata = '0; gnt_i = 1'b0;
    rxvalid1 = 1'b0; rxdata1 = '0; gnt1 = 1'b0;
    step(); step();
    check("rst_req", {31'b0, req_o}, 0);
    check("rst_we", {31'b0, we_o}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_addr", w_addr, 0);
    check("rst_data", w_data, 0);
    check("rst_done", {31'b0, done_o}, 0);
    rst = 1'b1;
    step();

    // 1: full frame, bytes 00..1F, grant always high
    gnt_i = 1'b1;
    n0 = wa.size();
    for (int i = 0; i < 32; i++) begin
      send(8'(i));
      if (i == 0) check("t1_busy_on", {31'b0, busy}, 1);
      repeat (19) step();
    end
    check("t1_nwrites", 32'(wa.size() - n0), 8);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        bb = 8'(4 * k + j);
        exp_w = {exp_w[23:0], bb};
      end
      check("t1_addr", wa[n0 + k], BASE + 32'(4 * k));
      check("t1_data", wd[n0 + k], exp_w);
    end
    check("t1_done_cnt", 32'(done_n), 1);
    check("t1_busy_off", {31'b0, busy}, 0);

    // 2: 6-cycle grant stall with 0xAA arriving during the wait
    gnt_i = 1'b0;
    n0 = wa.size();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    for (int c = 0; c < 7; c++) begin
      check("t2_req_held", {31'b0, req_o}, 1);
      check("t2_we_held", {31'b0, we_o}, 1);
      check("t2_addr_held", w_addr, BASE);
      check("t2_data_held", w_data, 32'h01020304);
      if (c == 6) gnt_i = 1'b1;
      if (c == 2) send(8'hAA);
      else step();
    end
    check("t2_req_drop", {31'b0, req_o}, 0);
    send(8'h05); send(8'h06); send(8'h07);
    repeat (3) step();
    check("t2_nwrites", 32'(wa.size() - n0), 2);
    check("t2_w0", wd[n0], 32'h01020304);
    check("t2_a1", wa[n0 + 1], BASE + 32'h4);
    check("t2_w1", wd[n0 + 1], 32'hAA050607);
    check("t2_no_ovr", 32'(ovr_n), 0);

    // 3: two bytes during one stalled write; second is dropped
    gnt_i = 1'b0;
    send(8'h08); send(8'h09); send(8'h0A); send(8'h0B);
    send(8'hBB);
    send(8'hCC);
    check("t3_ovr_pulse", {31'b0, err_ovr}, 1);
    step();
    check("t3_ovr_cnt", 32'(ovr_n), 1);
    gnt_i = 1'b1;
    step();
    gnt_i = 1'b0;
    send(8'hDD); send(8'hEE); send(8'hFF);
    step();
    check("t3_w2", wd[n0 + 2], 32'h08090A0B);
    check("t3_req_w3", {31'b0, req_o}, 1);
    check("t3_addr_w3", w_addr, BASE + 32'hC);
    check("t3_data_w3", w_data, 32'hBBDDEEFF);

    // 5: reset while word 3 waits for its grant
    n0 = wa.size();
    rst = 1'b0;
    #1;
    check("t5_req", {31'b0, req_o}, 0);
    check("t5_we", {31'b0, we_o}, 0);
    check("t5_busy", {31'b0, busy}, 0);
    check("t5_addr", w_addr, 0);
    check("t5_data", w_data, 0);
    step();
    rst = 1'b1;
    gnt_i = 1'b1;
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    repeat (3) step();
    check("t5_nwrites", 32'(wa.size() - n0), 1);
    check("t5_addr_after", wa[n0], BASE);
    check("t5_data_after", wd[n0], 32'h12345678);
    rst = 1'b0; step(); rst = 1'b1; step();

    // 4: partial word dropped on timeout, then a clean word at BASE
    n0 = wa.size();
    send(8'h11); send(8'h22);
    repeat (49999) step();
    check("t4_no_tmo_early", {31'b0, err_tmo}, 0);
    step();
    check("t4_tmo_pulse", {31'b0, err_tmo}, 1);
    check("t4_busy_off", {31'b0, busy}, 0);
    send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    repeat (3) step();
    check("t4_tmo_cnt", 32'(tmo_n), 1);
    check("t4_nwrites", 32'(wa.size() - n0), 1);
    check("t4_addr", wa[n0], BASE);
    check("t4_data", wd[n0], 32'h33445566);
    rst = 1'b0; step(); rst = 1'b1; step();

    // 6: single-word frame, done pulse, then timeout boundary on dut1
    n0 = wa1.size();
    send1(8'hDE); send1(8'hAD); send1(8'hBE); send1(8'hEF);
    check("t6_req", {31'b0, req1}, 1);
    check("t6_addr", waddr1, BASE);
    check("t6_data", wdata1, 32'hDEADBEEF);
    check("t6_no_done_yet", {31'b0, done1}, 0);
    step(); step();
    gnt1 = 1'b1;
    step();
    gnt1 = 1'b0;
    check("t6_req_drop", {31'b0, req1}, 0);
    check("t6_done", {31'b0, done1}, 1);
    check("t6_busy_off", {31'b0, busy1}, 0);
    check("t6_nwrites", 32'(wa1.size() - n0), 1);
    check("t6_wdata", wd1[n0], 32'hDEADBEEF);
    send1(8'h77);
    check("t6_done_1cyc", {31'b0, done1}, 0);
    check("t6_newframe", {31'b0, busy1}, 1);
    repeat (9) step();
    send1(8'h02);
    check("t6_byte_wins", 32'(tmo1_n), 0);
    check("t6_busy_kept", {31'b0, busy1}, 1);
    repeat (9) step();
    check("t6_tmo_not_yet", {31'b0, tmo1}, 0);
    step();
    check("t6_tmo_pulse", {31'b0, tmo1}, 1);
    check("t6_busy_idle", {31'b0, busy1}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
